muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//   Sequencer for the RV32M multiply/divide unit used by the EX stage.
//   Accepts a held-valid request, runs a MUL_LAT-stage multiplier or a 32-step radix-2 divider.
//   Returns the result with a one-cycle completion pulse.
//   EX raises its hazard stall while op_valid && ~op_ready.
// PARAMETERS
//   XLEN     32  operand/result width (only 32 supported)
//   MUL_LAT  2   multiplier pipeline depth in cycles, legal 1..4
// PORTS
//   clk       in   1     single clock, all state on posedge
//   rst       in   1     synchronous, active-high reset
//   op_stall  in   1     freeze all state (counter, FSM, result) this cycle
//   op_valid  in   1     request; held high by EX until op_ready seen
//   op        in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   op1       in   XLEN  rs1 operand (multiplicand / dividend)
//   op2       in   XLEN  rs2 operand (multiplier / divisor)
//   op_ready  out  1     completion pulse; op_out valid in this cycle
//   op_out    out  XLEN  registered result, holds last result until next completion
// BEHAVIOUR
//   Reset: state=IDLE, op_ready=0, op_out=0, counter=0, operand regs=0. rst has priority over op_stall.
//   States: IDLE, MUL, DIV, FIX, DONE.
//   IDLE: op_valid=1 in cycle N captures op/op1/op2.
//     - MUL-class -> MUL.
//     - DIV-class with op2==0 or (signed, op1==0x80000000, op2==0xFFFFFFFF) -> DONE (fast path).
//     - Other DIV-class -> DIV.
//   MUL: 33x33 signed product, operand extension per op, MUL_LAT cycles -> DONE.
//     - op_ready at N+1+MUL_LAT.
//     - MUL returns low 32 bits; MULH/MULHSU/MULHU return bits [63:32].
//   DIV: unsigned restoring on magnitudes, 1 quotient bit/cycle, 6-bit counter 0..31, 32 cycles -> FIX.
//   FIX: quotient sign = sign(op1)^sign(op2), remainder sign = sign(op1) (signed ops only) -> DONE.
//     - op_ready at N+34.
//   DONE: op_ready=1 for exactly one cycle, then IDLE.
//     - op_valid still high in DONE is the same request and is not re-captured.
//     - A new request is captured in the following IDLE cycle.
//   Special results:
//     - div-by-zero: DIV/DIVU -> 0xFFFFFFFF, REM/REMU -> op1.
//     - overflow: DIV -> 0x80000000, REM -> 0.
//     - Special-case op_ready at N+1.
//   op_valid deasserted in MUL/DIV/FIX (EX flush/stall): abort.
//     - Next state IDLE, op_out unchanged, no op_ready.
//   op_stall=1: no state change anywhere.
//     - Counter and MUL pipe hold.
//     - In DONE, op_ready stays high for every stalled cycle.
//     - Completion is delayed by the number of stalled cycles.
//   op_ready is never asserted without a captured request; op_out changes only on the entry to DONE.
//   rst mid-operation: next cycle IDLE, op_ready=0, op_out=0; the in-flight op is lost.
// STRUCTURE
//   Shared in macro.v:
//     - `MD_MUL..`MD_REMU funct3 constants
//     - `MD_ST_IDLE..`MD_ST_DONE state encodings
//     - `MD_DIV_STEPS=32
//   Sub-module mul_pipe (MUL_LAT register stages, 33x33 signed multiply, stall input).
//   Divider step, counter and FSM stay in muldiv_seq.
// TESTING
//   1. MUL op1=7, op2=0xFFFFFFFD, MUL_LAT=2, capture at N -> op_ready at N+3, op_out=0xFFFFFFEB.
//   2. MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
//   3. DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD at N+34; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
//   4. DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100, both at N+1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
//   5. DIV started, op_valid dropped at N+10 -> no op_ready, back to IDLE; next MUL 3*5 -> 15 at its N'+3.
//   6. op_stall high 5 cycles during DIV -> op_ready at N+39; rst at N+5 of DIV -> op_ready=0, op_out=0 next cycle.
//   7. Back-to-back: MUL ready at M, op_valid kept high with new operands -> second capture at M+1.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 codes,
// FSM states, divider step count and small op-class helpers.
package muldiv_seq_pkg;

  localparam int DIV_STEPS = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  function automatic logic is_div(input md_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_rem(input md_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic div_signed(input md_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_seq_mul_pipe.sv
// 33x33 signed multiplier followed by MUL_LAT register stages; the whole
// pipe freezes when en is low.
module muldiv_seq_mul_pipe #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic signed [XLEN:0]   a,
  input  logic signed [XLEN:0]   b,
  output logic [2*XLEN-1:0]      p
);

  logic signed [2*XLEN+1:0] prod;
  logic [2*XLEN-1:0] stage_q [MUL_LAT];
  logic [2*XLEN-1:0] stage_d [MUL_LAT];
  logic              pipe_unused;

  assign prod        = a * b;
  assign pipe_unused = ^prod[2*XLEN+1:2*XLEN];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    stage_d = stage_q;
    if (en) begin
      stage_d[0] = prod[2*XLEN-1:0];
      for (int i = 1; i < MUL_LAT; i++) stage_d[i] = stage_q[i-1];
    end
  end

  // NOTE: the stage array is a small register bank, so it is reset like any flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign p = stage_q[MUL_LAT-1];

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: pipelined multiply, 32-step restoring
// divide with sign fix-up, one-cycle op_ready completion pulse.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_stall,
  input  logic            op_valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            op_ready,
  output logic [XLEN-1:0] op_out
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state_q, state_d;
  md_op_e          op_q, op_d, op_in, mul_op;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, out_q, out_d;
  logic [5:0]      cnt_q, cnt_d;

  logic [XLEN-1:0]   mul_a, mul_b;
  logic signed [XLEN:0] mul_a_ext, mul_b_ext;
  logic [2*XLEN-1:0] mul_p;

  logic            in_signed, in_dz, in_ovf;
  logic [XLEN-1:0] in_mag1, special_res;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] divisor, q_fix, r_fix;
  logic [XLEN+1:0] trial;
  logic            div_unused;

  assign op_in = md_op_e'(op);

  // In IDLE the pipe sees the live operands so the product is ready MUL_LAT cycles after capture.
  assign mul_op    = (state_q == ST_IDLE) ? op_in : op_q;
  assign mul_a     = (state_q == ST_IDLE) ? op1   : a_q;
  assign mul_b     = (state_q == ST_IDLE) ? op2   : b_q;
  assign mul_a_ext = {(mul_op != OP_MULHU) & mul_a[XLEN-1], mul_a};
  assign mul_b_ext = {((mul_op == OP_MUL) || (mul_op == OP_MULH)) & mul_b[XLEN-1], mul_b};

  muldiv_seq_mul_pipe #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) u_mul_pipe (
    .clk (clk),
    .rst (rst),
    .en  (~op_stall),
    .a   (mul_a_ext),
    .b   (mul_b_ext),
    .p   (mul_p)
  );

  assign in_signed   = div_signed(op_in);
  assign in_dz       = (op2 == '0);
  assign in_ovf      = in_signed && (op1 == MIN_NEG) && (op2 == '1);
  assign in_mag1     = (in_signed && op1[XLEN-1]) ? -op1 : op1;
  assign special_res = in_dz ? (is_rem(op_in) ? op1 : '1)
                             : (is_rem(op_in) ? '0  : MIN_NEG);

  assign a_neg      = div_signed(op_q) & a_q[XLEN-1];
  assign b_neg      = div_signed(op_q) & b_q[XLEN-1];
  assign divisor    = b_neg ? -b_q : b_q;
  assign trial      = {1'b0, rem_q, quo_q[XLEN-1]} - {2'b00, divisor};
  assign div_unused = trial[XLEN];
  assign q_fix      = (a_neg ^ b_neg) ? -quo_q : quo_q;
  assign r_fix      = a_neg ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    if (!op_stall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            op_d  = op_in;
            a_d   = op1;
            b_d   = op2;
            cnt_d = '0;
            rem_d = '0;
            quo_d = in_mag1;
            if (!is_div(op_in)) begin
              state_d = ST_MUL;
            end else if (in_dz || in_ovf) begin
              out_d   = special_res;
              state_d = ST_DONE;
            end else begin
              state_d = ST_DIV;
            end
          end
        end
        ST_MUL: begin
          if (!op_valid) begin
            state_d = ST_IDLE;
          end else if (cnt_q == 6'(MUL_LAT - 1)) begin
            out_d   = (op_q == OP_MUL) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        ST_DIV: begin
          if (!op_valid) begin
            state_d = ST_IDLE;
          end else begin
            rem_d = trial[XLEN+1] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], ~trial[XLEN+1]};
            if (cnt_q == 6'(DIV_STEPS - 1)) begin
              cnt_d   = '0;
              state_d = ST_FIX;
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end
        end
        ST_FIX: begin
          if (!op_valid) begin
            state_d = ST_IDLE;
          end else begin
            out_d   = is_rem(op_q) ? r_fix : q_fix;
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign op_ready = (state_q == ST_DONE);
  assign op_out   = out_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_seq;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst, op_stall, op_valid;
  logic [2:0]  op;
  logic [31:0] op1, op2;
  logic        op_ready;
  logic [31:0] op_out;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_out = '0;

  muldiv_seq #(.XLEN(32), .MUL_LAT(MUL_LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_stall (op_stall),
    .op_valid (op_valid),
    .op       (op),
    .op1      (op1),
    .op2      (op2),
    .op_ready (op_ready),
    .op_out   (op_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ub = longint'({32'b0, b});
    logic [63:0] p;
    int          ia = a;
    int          ib = b;
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic sgn = (o == 3'd4) || (o == 3'd6);
    if (o < 3'd4) return 1 + MUL_LAT;
    if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 34;
  endfunction

  // Presents a request now and waits for op_ready; extra covers a request
  // presented during a DONE cycle, stall_len cycles of op_stall start at stall_at.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int extra, input int stall_at, input int stall_len, input string tag);
    logic [31:0] exp = ref_result(o, a, b);
    int          lat = ref_lat(o, a, b) + extra + stall_len;
    int          n = 0;
    op = o; op1 = a; op2 = b; op_valid = 1'b1;
    while (n < 200) begin
      tick();
      n++;
      if (op_ready) break;
      if (stall_len > 0 && n == stall_at) op_stall = 1'b1;
      if (stall_len > 0 && n == stall_at + stall_len) op_stall = 1'b0;
    end
    op_stall = 1'b0;
    check({tag, "_lat"}, n, lat);
    check({tag, "_res"}, op_out, exp);
    last_out = exp;
  endtask

  task automatic idle();
    op_valid = 1'b0;
    tick();
    check("pulse_end", {31'b0, op_ready}, 32'd0);
  endtask

  initial begin
    logic chain;
    logic [2:0] ro;
    logic [31:0] ra, rb;
    int seen;
    rst = 1'b1; op_stall = 1'b0; op_valid = 1'b0; op = '0; op1 = '0; op2 = '0;
    tick(); tick();
    check("rst_ready", {31'b0, op_ready}, 32'd0);
    check("rst_out", op_out, 32'd0);
    rst = 1'b0;
    tick();

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 0, 0, "mul");         idle();
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, "mulh"); idle();
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, "mulhu"); idle();
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, "mulhsu");      idle();
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, "div");         idle();
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, "rem");         idle();
    run_op(3'd5, 32'd100, 32'd7, 0, 0, 0, "divu");              idle();
    run_op(3'd7, 32'd100, 32'd7, 0, 0, 0, "remu");              idle();
    run_op(3'd5, 32'd100, 32'd0, 0, 0, 0, "divu_dz");           idle();
    run_op(3'd7, 32'd100, 32'd0, 0, 0, 0, "remu_dz");           idle();
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, "div_ovf"); idle();
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, "rem_ovf"); idle();

    // Abort: DIV whose op_valid drops at N+10 must never complete.
    run_op(3'd5, 32'd1000, 32'd3, 0, 0, 0, "pre_abort"); idle();
    op = 3'd4; op1 = 32'd12345; op2 = 32'd7; op_valid = 1'b1;
    seen = 0;
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (op_ready) seen++;
      if (n == 10) op_valid = 1'b0;
    end
    check("abort_noready", seen, 0);
    check("abort_out", op_out, last_out);
    run_op(3'd0, 32'd3, 32'd5, 0, 0, 0, "after_abort"); idle();

    // Five stalled cycles in the middle of a divide push completion to N+39.
    run_op(3'd4, 32'hFFFF_FF00, 32'd9, 0, 10, 5, "div_stall"); idle();

    // Stall while in DONE keeps op_ready high.
    run_op(3'd0, 32'd12345, 32'd678, 0, 0, 0, "mul_done_stall");
    op_stall = 1'b1;
    tick(); check("done_stall1", {31'b0, op_ready}, 32'd1);
    tick(); check("done_stall2", {31'b0, op_ready}, 32'd1);
    check("done_stall_out", op_out, last_out);
    op_stall = 1'b0;
    idle();

    // Reset in the middle of a divide clears everything next cycle.
    op = 3'd5; op1 = 32'd999; op2 = 32'd4; op_valid = 1'b1;
    for (int n = 1; n <= 5; n++) tick();
    rst = 1'b1;
    tick();
    check("midrst_ready", {31'b0, op_ready}, 32'd0);
    check("midrst_out", op_out, 32'd0);
    rst = 1'b0; op_valid = 1'b0;
    tick();
    last_out = '0;

    // Back-to-back: new operands presented in the DONE cycle.
    run_op(3'd0, 32'd11, 32'd13, 0, 0, 0, "b2b_first");
    run_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 1, 0, 0, "b2b_second");
    idle();

    chain = 1'b0;
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(ro, ra, rb, chain ? 1 : 0, 0, 0, "rnd");
      chain = ($urandom_range(0, 3) == 0);
      if (!chain) idle();
    end
    if (chain) idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
